// File: rtl/uart_tx_core.sv
// ============================================================================
// uart_tx_core : FIFO-buffered UART transmitter; optional parity via UART_TX_PARITY_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_core #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_en,
    input  logic [DATA_WIDTH-1:0]         load_byte,
    input  logic                          load,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          ftdi_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CLKS_PER_BIT < 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1) ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_core: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    state_t                state, state_next;
    logic [CW-1:0]         baud_cnt, baud_next;
    logic [BW-1:0]         bit_cnt, bit_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  line_next;
    logic                  tick;
    logic                  fifo_nonempty;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit, parity_next;
`endif

    assign ready         = (fifo_count != (AW + 1)'(FIFO_DEPTH));
    assign push          = load && ready;
    assign head          = mem[rd_ptr];
    assign fifo_nonempty = (fifo_count != '0);
    assign busy          = (state != IDLE);
    assign tick          = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= load_byte;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            ftdi_tx   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            ftdi_tx   <= line_next;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = tick ? '0 : baud_cnt + 1'b1;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        pop        = 1'b0;
        line_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (tx_en && fifo_nonempty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^head) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    bit_next   = '0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt == BW'(STOP_BITS - 1)) begin
                        bit_next = '0;
                        // Back-to-back frames: chain straight into START with no idle gap.
                        if (tx_en && fifo_nonempty) begin
                            pop        = 1'b1;
                            shift_next = head;
                            state_next = START;
`ifdef UART_TX_PARITY_EN
                            parity_next = (^head) ^ (PARITY_ODD != 0);
`endif
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase

        // The line is registered from the upcoming state so it changes on the same edge.
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_next = parity_next;
`endif
            default: line_next = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core: directed frames, FIFO full, mid-frame reset, two stop bits.
`default_nettype none

module tb_uart_tx_core;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en_a, load_a, ready_a, busy_a, line_a;
    logic [7:0] load_byte_a;
    logic [2:0] fifo_count_a;
    logic       tx_en_b, load_b, ready_b, busy_b, line_b;
    logic [7:0] load_byte_b;
    logic [2:0] fifo_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .tx_en(tx_en_a), .load_byte(load_byte_a), .load(load_a),
        .ready(ready_a), .fifo_count(fifo_count_a), .busy(busy_a), .ftdi_tx(line_a)
    );

    uart_tx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .tx_en(tx_en_b), .load_byte(load_byte_b), .load(load_b),
        .ready(ready_b), .fifo_count(fifo_count_b), .busy(busy_b), .ftdi_tx(line_b)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit idx of a frame: 0 start, 1..8 data LSB first, optional even parity, then stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PB == 1 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    // Called on the negedge of the first start-bit cycle; returns on the negedge after the frame.
    task automatic check_frame(input logic [7:0] d, input int stops, input bit sel_b);
        int nb;
        nb = 9 + PB + stops;
        for (int k = 0; k < nb * CPB; k++) begin
            check_value("frame_line", sel_b ? line_b : line_a, frame_bit(d, k / CPB));
            if (k == 0) check_value("frame_busy", sel_b ? busy_b : busy_a, 1);
            @(negedge clk);
        end
    endtask

    logic [7:0] fill_bytes [5];

    initial begin
        fill_bytes[0] = 8'h55; fill_bytes[1] = 8'hA3; fill_bytes[2] = 8'h0F;
        fill_bytes[3] = 8'hC8; fill_bytes[4] = 8'h99;
        rst = 1'b1;
        tx_en_a = 0; load_a = 0; load_byte_a = 0;
        tx_en_b = 0; load_b = 0; load_byte_b = 0;
        repeat (2) @(negedge clk);
        check_value("rst_line", line_a, 1);
        check_value("rst_busy", busy_a, 0);
        check_value("rst_count", fifo_count_a, 0);
        check_value("rst_ready", ready_a, 1);

        // Single frame of 0x47
        rst = 1'b0; tx_en_a = 1; load_a = 1; load_byte_a = 8'h47;
        @(negedge clk);
        load_a = 0;
        check_value("push_count", fifo_count_a, 1);
        check_value("push_line", line_a, 1);
        check_value("push_busy", busy_a, 0);
        @(negedge clk);
        check_frame(8'h47, 1, 1'b0);
        check_value("end_busy", busy_a, 0);
        check_value("end_line", line_a, 1);
        check_value("end_count", fifo_count_a, 0);

        // Fill FIFO with tx disabled; fifth load must be dropped
        tx_en_a = 0;
        for (int i = 0; i < 5; i++) begin
            load_a = 1; load_byte_a = fill_bytes[i];
            @(negedge clk);
            if (i == 2) check_value("ready_3", ready_a, 1);
        end
        load_a = 0;
        check_value("full_count", fifo_count_a, 4);
        check_value("full_ready", ready_a, 0);
        check_value("full_busy", busy_a, 0);
        check_value("full_line", line_a, 1);
        tx_en_a = 1;
        @(negedge clk);
        check_value("pop_count", fifo_count_a, 3);
        for (int i = 0; i < 4; i++) check_frame(fill_bytes[i], 1, 1'b0);
        check_value("drain_line", line_a, 1);
        check_value("drain_busy", busy_a, 0);
        check_value("drain_count", fifo_count_a, 0);

        // Push and pop on the same edge, then reset during data bit 3
        load_a = 1; load_byte_a = 8'h47;
        @(negedge clk);
        load_byte_a = 8'h12;
        @(negedge clk);
        load_a = 0;
        check_value("pushpop_count", fifo_count_a, 1);
        check_value("pushpop_line", line_a, 0);
        repeat (17) @(negedge clk);
        check_value("bit3_line", line_a, 0);
        rst = 1'b1;
        #1;
        check_value("midrst_line", line_a, 1);
        check_value("midrst_busy", busy_a, 0);
        check_value("midrst_count", fifo_count_a, 0);
        check_value("midrst_ready", ready_a, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            check_value("postrst_line", line_a, 1);
            check_value("postrst_busy", busy_a, 0);
            @(negedge clk);
        end

        // Two stop bits, tx_en dropped mid-frame with another byte queued
        tx_en_b = 1; load_b = 1; load_byte_b = 8'h47;
        @(negedge clk);
        load_b = 0;
        @(negedge clk);
        for (int k = 0; k < (11 + PB) * CPB; k++) begin
            check_value("b_line", line_b, frame_bit(8'h47, k / CPB));
            if (k == 10) begin
                tx_en_b = 0; load_b = 1; load_byte_b = 8'h3C;
            end
            if (k == 11) load_b = 0;
            @(negedge clk);
        end
        check_value("b_hold_count", fifo_count_b, 1);
        for (int k = 0; k < 20; k++) begin
            check_value("b_hold_line", line_b, 1);
            check_value("b_hold_busy", busy_b, 0);
            @(negedge clk);
        end
        tx_en_b = 1;
        @(negedge clk);
        check_frame(8'h3C, 2, 1'b1);
        check_value("b_end_count", fifo_count_b, 0);
        check_value("b_end_busy", busy_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
